// File: rtl/button_pkg.sv
// Shared definitions for the button event scheduler.
// Event type encodings and output FSM states.
package button_pkg;

    localparam int EVT_W = 2;

    typedef logic [EVT_W-1:0] evt_t;

    localparam evt_t EVT_PRESS   = 2'b00;
    localparam evt_t EVT_RELEASE = 2'b01;
    localparam evt_t EVT_LONG    = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_SHOW
    } state_t;

endpackage

// File: rtl/button_event_scheduler_tracker.sv
// Per-button edge detect, hold timer and pending event bits.
// Raises a one-cycle overflow strobe when an event merges into a pending one.
module button_tracker #(
    parameter int LONG_PRESS_TIME = 10_000_000,
    parameter int HOLD_LEN        = 24
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_clr_press,
    input  logic i_clr_long,
    input  logic i_clr_rel,
    output logic o_press_p,
    output logic o_long_p,
    output logic o_rel_p,
    output logic o_ovf
);

    logic                r_btn_q;
    logic                r_press_p;
    logic                r_long_p;
    logic                r_rel_p;
    logic                r_long_done;
    logic [HOLD_LEN-1:0] r_hold_cnt;

    logic w_rise;
    logic w_fall;
    logic w_held;
    logic w_long_hit;

    assign w_rise     = i_btn & ~r_btn_q;
    assign w_fall     = ~i_btn & r_btn_q;
    assign w_held     = i_btn & r_btn_q & ~r_long_done;
    assign w_long_hit = w_held &&
                        (r_hold_cnt == HOLD_LEN'(LONG_PRESS_TIME - 1));

    // Merge detection: a set against a pending bit that is not being drained.
    assign o_ovf = (w_rise     & r_press_p & ~i_clr_press) |
                   (w_long_hit & r_long_p  & ~i_clr_long)  |
                   (w_fall     & r_rel_p   & ~i_clr_rel);

    assign o_press_p = r_press_p;
    assign o_long_p  = r_long_p;
    assign o_rel_p   = r_rel_p;

    // Level history, pending bits and hold timer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_btn_q     <= i_btn;
            r_press_p   <= 1'b0;
            r_long_p    <= 1'b0;
            r_rel_p     <= 1'b0;
            r_long_done <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_btn_q   <= i_btn;
            r_press_p <= w_rise     | (r_press_p & ~i_clr_press);
            r_long_p  <= w_long_hit | (r_long_p  & ~i_clr_long);
            r_rel_p   <= w_fall     | (r_rel_p   & ~i_clr_rel);
            if (w_rise || w_fall) begin
                r_hold_cnt <= '0;
            end else if (w_held && !w_long_hit) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            if (w_rise) begin
                r_long_done <= 1'b0;
            end else if (w_long_hit) begin
                r_long_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Serialises per-button press/release/long-press events onto one
// valid/ready channel with round-robin arbitration across buttons.
module button_event_scheduler
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int LONG_PRESS_TIME = 10_000_000,
    parameter int HOLD_LEN        = 24,
    localparam int ID_W           = $clog2(NUM_BUTTONS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_BUTTONS-1:0] i_btn_db,
    output logic                   o_evt_valid,
    input  logic                   i_evt_ready,
    output logic [ID_W-1:0]        o_evt_id,
    output logic [EVT_W-1:0]       o_evt_type,
    output logic                   o_overflow,
    input  logic                   i_clr_overflow
);

    logic [NUM_BUTTONS-1:0] w_press_p;
    logic [NUM_BUTTONS-1:0] w_long_p;
    logic [NUM_BUTTONS-1:0] w_rel_p;
    logic [NUM_BUTTONS-1:0] w_ovf;
    logic [NUM_BUTTONS-1:0] w_pend;
    logic [NUM_BUTTONS-1:0] w_clr_press;
    logic [NUM_BUTTONS-1:0] w_clr_long;
    logic [NUM_BUTTONS-1:0] w_clr_rel;

    state_t          r_state;
    state_t          w_state_n;
    logic [ID_W-1:0] r_last_grant;
    logic [ID_W-1:0] r_evt_id;
    evt_t            r_evt_type;
    logic            r_overflow;

    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic [ID_W:0]   w_idx;
    evt_t            w_type;
    logic            w_load;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_trk
        button_tracker #(
            .LONG_PRESS_TIME(LONG_PRESS_TIME),
            .HOLD_LEN       (HOLD_LEN)
        ) u_trk (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_btn      (i_btn_db[g]),
            .i_clr_press(w_clr_press[g]),
            .i_clr_long (w_clr_long[g]),
            .i_clr_rel  (w_clr_rel[g]),
            .o_press_p  (w_press_p[g]),
            .o_long_p   (w_long_p[g]),
            .o_rel_p    (w_rel_p[g]),
            .o_ovf      (w_ovf[g])
        );
    end

    assign w_pend = w_press_p | w_long_p | w_rel_p;

    // Round-robin search starting after the last granted button.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int off = 1; off <= NUM_BUTTONS; off++) begin
            w_idx = {1'b0, r_last_grant} + (ID_W+1)'(off);
            if (w_idx >= (ID_W+1)'(NUM_BUTTONS)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_BUTTONS);
            end
            if (!w_found && w_pend[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[ID_W-1:0];
            end
        end
    end

    // Within the winning button: press before long before release.
    always_comb begin
        w_type = EVT_RELEASE;
        if (w_press_p[w_win]) begin
            w_type = EVT_PRESS;
        end else if (w_long_p[w_win]) begin
            w_type = EVT_LONG;
        end
    end

    // Output FSM next state and load decision.
    always_comb begin
        w_state_n = r_state;
        w_load    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_load    = 1'b1;
                    w_state_n = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (i_evt_ready) begin
                    w_load    = w_found;
                    w_state_n = w_found ? ST_SHOW : ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Drain the pending bit of the event being loaded.
    always_comb begin
        w_clr_press = '0;
        w_clr_long  = '0;
        w_clr_rel   = '0;
        if (w_load) begin
            w_clr_press[w_win] = (w_type == EVT_PRESS);
            w_clr_long[w_win]  = (w_type == EVT_LONG);
            w_clr_rel[w_win]   = (w_type == EVT_RELEASE);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Presented event and arbitration pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_evt_id     <= '0;
            r_evt_type   <= EVT_PRESS;
            r_last_grant <= ID_W'(NUM_BUTTONS - 1);
        end else if (w_load) begin
            r_evt_id     <= w_win;
            r_evt_type   <= w_type;
            r_last_grant <= w_win;
        end
    end

    // Sticky overflow; a new merge beats a clear in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (|w_ovf) begin
            r_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_evt_valid = (r_state == ST_SHOW);
    assign o_evt_id    = r_evt_id;
    assign o_evt_type  = r_evt_type;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler.
// Directed stimulus pushes expected events; a monitor pops on handshake.
module tb_button_event_scheduler;
    import button_pkg::*;

    localparam int N   = 4;
    localparam int LPT = 20;
    localparam int HL  = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn;
    logic         ready;
    logic         clr;
    logic         valid;
    logic [1:0]   id;
    evt_t         typ;
    logic         ovf;

    typedef struct packed {
        logic [1:0] id;
        evt_t       typ;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    logic       stall_q = 1'b0;
    logic [1:0] id_q    = '0;
    evt_t       typ_q   = '0;

    button_event_scheduler #(
        .NUM_BUTTONS    (N),
        .LONG_PRESS_TIME(LPT),
        .HOLD_LEN       (HL)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_btn_db      (btn),
        .o_evt_valid   (valid),
        .i_evt_ready   (ready),
        .o_evt_id      (id),
        .o_evt_type    (typ),
        .o_overflow    (ovf),
        .i_clr_overflow(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input evt_t t);
        exp_t e;
        e.id  = 2'(i);
        e.typ = t;
        sb.push_back(e);
    endtask

    // Monitor: stall stability and scoreboard pop on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q && valid) begin
                chk("stall_id", int'(id), int'(id_q));
                chk("stall_type", int'(typ), int'(typ_q));
            end
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got id=%0d type=%0d required none",
                             id, typ);
                end else begin
                    mon_e = sb.pop_front();
                    chk("evt_id", int'(id), int'(mon_e.id));
                    chk("evt_type", int'(typ), int'(mon_e.typ));
                end
            end
            stall_q <= valid && !ready;
            id_q    <= id;
            typ_q   <= typ;
        end
    end

    initial begin
        rst_n = 1'b0;
        btn   = 4'b0010;
        ready = 1'b1;
        clr   = 1'b0;
        tick(3);
        chk("rst_valid", int'(valid), 0);
        chk("rst_id", int'(id), 0);
        chk("rst_type", int'(typ), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        tick(6);
        chk("held_no_press", int'(valid), 0);

        // release of button held through reset, 2-cycle latency
        push(1, EVT_RELEASE);
        btn = 4'b0000;
        tick(1);
        chk("lat_e0_valid", int'(valid), 0);
        tick(1);
        chk("lat_e1_valid", int'(valid), 1);
        chk("lat_e1_id", int'(id), 1);
        chk("lat_e1_type", int'(typ), int'(EVT_RELEASE));
        tick(4);

        // simultaneous rises, round-robin from reset
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        push(0, EVT_PRESS);
        push(2, EVT_PRESS);
        btn = 4'b0101;
        tick(2);
        chk("rr_c1_valid", int'(valid), 1);
        chk("rr_c1_id", int'(id), 0);
        tick(1);
        chk("rr_c2_valid", int'(valid), 1);
        chk("rr_c2_id", int'(id), 2);
        tick(1);
        chk("rr_c3_valid", int'(valid), 0);
        push(0, EVT_RELEASE);
        push(2, EVT_RELEASE);
        btn = 4'b0000;
        tick(6);
        push(0, EVT_PRESS);
        push(2, EVT_PRESS);
        btn = 4'b0101;
        tick(2);
        chk("rr_again_c1_id", int'(id), 0);
        tick(1);
        chk("rr_again_c2_id", int'(id), 2);
        tick(3);
        push(0, EVT_RELEASE);
        push(2, EVT_RELEASE);
        btn = 4'b0000;
        tick(6);

        // long press on button 3, held 50 cycles
        push(3, EVT_PRESS);
        push(3, EVT_LONG);
        push(3, EVT_RELEASE);
        btn = 4'b1000;
        tick(21);
        chk("long_e20_valid", int'(valid), 0);
        tick(1);
        chk("long_e21_valid", int'(valid), 1);
        chk("long_e21_id", int'(id), 3);
        chk("long_e21_type", int'(typ), int'(EVT_LONG));
        tick(28);
        btn = 4'b0000;
        tick(6);

        // overflow while stalled
        ready = 1'b0;
        push(0, EVT_PRESS);
        btn = 4'b0001;
        tick(3);
        push(1, EVT_PRESS);
        push(1, EVT_RELEASE);
        btn = 4'b0011;
        tick(1);
        btn = 4'b0001;
        tick(1);
        chk("ovf_pre", int'(ovf), 0);
        btn = 4'b0011;
        tick(1);
        chk("ovf_set", int'(ovf), 1);
        chk("stall_hold_id", int'(id), 0);
        chk("stall_hold_type", int'(typ), int'(EVT_PRESS));
        tick(3);
        ready = 1'b1;
        tick(6);
        push(0, EVT_RELEASE);
        push(1, EVT_RELEASE);
        btn = 4'b0000;
        tick(6);

        // clear, then clear colliding with a new merge
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);
        ready = 1'b0;
        push(2, EVT_PRESS);
        btn = 4'b0100;
        tick(3);
        push(2, EVT_PRESS);
        push(2, EVT_RELEASE);
        btn = 4'b0000;
        tick(1);
        btn = 4'b0100;
        tick(1);
        btn = 4'b0000;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_vs_merge", int'(ovf), 1);
        ready = 1'b1;
        tick(6);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;

        // reset with a presented event and three pending
        ready = 1'b0;
        btn = 4'b1111;
        tick(3);
        chk("pre_rst_valid", int'(valid), 1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        chk("rst_mid_valid", int'(valid), 0);
        chk("rst_mid_ovf", int'(ovf), 0);
        ready = 1'b1;
        tick(8);
        chk("no_stale", int'(valid), 0);
        push(0, EVT_RELEASE);
        push(1, EVT_RELEASE);
        push(2, EVT_RELEASE);
        push(3, EVT_RELEASE);
        btn = 4'b0000;
        tick(8);

        for (int i = 0; i < 50 && sb.size() > 0; i++) begin
            tick(1);
        end
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_scheduler.md
# button_event_scheduler

Collects the debounced outputs of up to `NUM_BUTTONS` debouncer instances, converts level changes into press, release and long-press events, and serialises them onto one valid/ready event channel. Arbitration across buttons is round-robin. It sits between the per-button debouncers and the display/mode controller, which consumes one event at a time.

## Interface
- `NUM_BUTTONS`, default 4: number of debounced inputs (2..8).
- `LONG_PRESS_TIME`, default 10_000_000: hold cycles before a long-press event (1 s at 10 MHz).
- `HOLD_LEN`, default 24: hold counter width; must satisfy 2^HOLD_LEN > LONG_PRESS_TIME.
- `clk  in  1`: single clock; all logic on rising edge.
- `rst_n  in  1`: reset; synchronous, active-low.
- `btn_db  in  NUM_BUTTONS`: debounced button levels, already synchronous to `clk`.
- `evt_valid  out  1`: event presented.
- `evt_ready  in  1`: consumer accepts the event when `evt_valid && evt_ready`.
- `evt_id  out  $clog2(NUM_BUTTONS)`: index of the button that raised the event.
- `evt_type  out  2`: 00 press, 01 release, 10 long press, 11 unused.
- `overflow  out  1`: sticky; an event merged into an already-pending identical event.
- `clr_overflow  in  1`: clears `overflow`.

## Operation
- Per button: previous level `btn_q`; pending bits `press_p`, `long_p`, `rel_p`; hold counter `hold_cnt`; and `long_done` flag.
- Rise (`btn_db=1, btn_q=0`): set `press_p`, clear `hold_cnt` and `long_done`.
- Fall: set `rel_p`, clear `hold_cnt`. A release is always reported, even after a long press.
- While held and `!long_done`, `hold_cnt` increments. When `hold_cnt == LONG_PRESS_TIME-1`, set `long_p` and `long_done`. The counter then stops, so at most one long press is reported per hold.
- Setting a pending bit that is already 1 and not being cleared this cycle sets `overflow`. The two events merge into one.
- If a pending bit is cleared by acceptance in the same cycle that a new event of the same type is set, the bit stays 1 and no overflow is raised.
- Within a button, event priority is press > long > release, which preserves chronological order.
- Across buttons, round-robin: search starts at `last_grant+1`, wrapping at `NUM_BUTTONS-1` → 0. `last_grant` resets to `NUM_BUTTONS-1`, so button 0 is served first.
- Output FSM states:
  - IDLE: `evt_valid=0`. If any pending bit is set, load `evt_id`/`evt_type` from the arbiter winner, clear that pending bit, update `last_grant`, then go to SHOW.
  - SHOW: `evt_valid=1`; `evt_id`/`evt_type` are held stable. On `evt_ready`, either load the next winner in the same cycle and stay in SHOW, or go to IDLE if nothing is pending.
- `clr_overflow` clears `overflow`. A simultaneous new overflow wins, leaving `overflow=1`.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - `btn_q <= btn_db`, so a button held through reset produces no press.
  - All pending bits, `hold_cnt`, `long_done` and `overflow` go to 0.
  - FSM goes to IDLE; `evt_valid=0`, `evt_id=0`, `evt_type=00`.
- Reset mid-operation discards the presented event and all pending events. The first edge after reset release is evaluated normally.
- Latency: `btn_db` changes before edge E0 → pending bit set at E0 → `evt_valid=1` after E1 (2 cycles) when idle and uncontended.
- Throughput: one event per cycle with `evt_ready` held high.
- Long press is flagged at the `LONG_PRESS_TIME`-th edge after the press edge.

## Structure
- Shared package `button_pkg`:
  - event type constants `EVT_PRESS`, `EVT_RELEASE`, `EVT_LONG`;
  - the `evt_type` width.
- Sub-module `button_tracker`, one instance per button:
  - contains the edge detect, hold counter, the three pending bits and the overflow strobe;
  - has an input port to clear a pending bit on acceptance.
- Top level holds the round-robin arbiter and the output FSM.

## Test plan
- Reset with `btn_db=4'b0010` held → no events. Then release button 1 → one event `evt_id=1, evt_type=01`, `evt_valid` rising 2 cycles after the change.
- Buttons 0 and 2 rise in the same cycle, `evt_ready=1` → event 0/press, then 2/press on consecutive cycles. Repeat the stimulus → order is still 0 then 2, because `last_grant=2` wraps the search to 0.
- With `LONG_PRESS_TIME=20`, hold button 3 for 50 cycles → press, long press (flagged 20 cycles after the press edge), then release. Exactly one long press is reported.
- Hold `evt_ready=0`; toggle button 1 twice (rise, fall, rise) → `overflow=1`. After ready is raised, one press and one release are delivered, and `evt_id`/`evt_type` stay stable while stalled.
- Assert `rst_n=0` while `evt_valid=1` with 3 events pending → after reset, `evt_valid=0` and no stale events appear.
- Assert `clr_overflow` in the same cycle as a new merge → `overflow` stays 1.
